// File: rtl/control_unit.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit datapath.
// Control outputs decode combinationally from the registered instruction word.
module control_unit #(
   parameter int          PC_WIDTH = 8,
   parameter logic [3:0]  ALU_ADD  = 4'b0000
) (
   input  logic                clock,
   input  logic                reset,
   input  logic                run,
   output logic                instr_req,
   output logic [PC_WIDTH-1:0] instr_addr,
   input  logic                instr_ack,
   input  logic [15:0]         instr_data,
   input  logic                zero_flag,
   input  logic                pos_flag,
   output logic                rf_write,
   output logic [2:0]          rs_addr,
   output logic [2:0]          rt_addr,
   output logic [2:0]          rd_addr,
   output logic [15:0]         imm_data,
   output logic [3:0]          alu_sel,
   output logic                imm_sel,
   output logic                halted,
   output logic                illegal_op
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_HALT   = 3'd4
   } state_t;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_ALU  = 4'h1;
   localparam logic [3:0] OP_ADDI = 4'h2;
   localparam logic [3:0] OP_BEQZ = 4'h4;
   localparam logic [3:0] OP_BGTZ = 4'h5;
   localparam logic [3:0] OP_JMP  = 4'h6;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [PC_WIDTH-1:0] PC_ONE = {{(PC_WIDTH-1){1'b0}}, 1'b1};

   function automatic logic [15:0] sext6_16(input logic [5:0] v);
      return {{10{v[5]}}, v};
   endfunction

   // PC arithmetic is modulo 2^PC_WIDTH, so the offset is extended only to PC width.
   function automatic logic [PC_WIDTH-1:0] sext6_pc(input logic [5:0] v);
      return {{(PC_WIDTH-6){v[5]}}, v};
   endfunction

   state_t              state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;

   logic [3:0]          op_s;
   logic                is_write_s;
   logic                is_illegal_s;
   logic                branch_taken_s;

   assign op_s       = ir_q[15:12];
   assign rd_addr    = ir_q[11:9];
   assign rs_addr    = ir_q[8:6];
   assign rt_addr    = ir_q[5:3];
   assign instr_addr = pc_q;

   // State, PC and instruction register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         pc_q    <= {PC_WIDTH{1'b0}};
         ir_q    <= 16'h0000;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         ir_q    <= ir_d;
      end
   end

   // Instruction decode into datapath controls
   always_comb begin
      imm_data     = sext6_16(ir_q[5:0]);
      alu_sel      = 4'b0000;
      imm_sel      = 1'b0;
      is_write_s   = 1'b0;
      is_illegal_s = 1'b0;
      case (op_s)
         OP_NOP: begin
            is_write_s = 1'b0;
         end
         OP_ALU: begin
            alu_sel    = {1'b0, ir_q[2:0]};
            is_write_s = 1'b1;
         end
         OP_ADDI: begin
            alu_sel    = ALU_ADD;
            imm_sel    = 1'b1;
            is_write_s = 1'b1;
         end
         // rs + 0 makes the datapath flags describe rs itself
         OP_BEQZ, OP_BGTZ: begin
            alu_sel  = ALU_ADD;
            imm_sel  = 1'b1;
            imm_data = 16'h0000;
         end
         OP_JMP, OP_HALT: begin
            is_write_s = 1'b0;
         end
         default: begin
            is_illegal_s = 1'b1;
         end
      endcase
   end

   // Branch condition evaluated from the live datapath flags
   always_comb begin
      if (op_s == OP_BEQZ) begin
         branch_taken_s = zero_flag;
      end else if (op_s == OP_BGTZ) begin
         branch_taken_s = pos_flag & ~zero_flag;
      end else begin
         branch_taken_s = 1'b0;
      end
   end

   // Next-state, PC/IR update and state-qualified outputs
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ir_d       = ir_q;
      instr_req  = 1'b0;
      rf_write   = 1'b0;
      illegal_op = 1'b0;
      halted     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_FETCH: begin
            instr_req = 1'b1;
            if (instr_ack) begin
               ir_d    = instr_data;
               pc_d    = pc_q + PC_ONE;
               state_d = S_DECODE;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            state_d = S_EXEC;
         end
         S_EXEC: begin
            rf_write   = is_write_s;
            illegal_op = is_illegal_s;
            // PC already points past this instruction, so offsets are relative to addr+1
            if (branch_taken_s) begin
               pc_d = pc_q + sext6_pc(ir_q[5:0]);
            end else if (op_s == OP_JMP) begin
               pc_d = ir_q[PC_WIDTH-1:0];
            end else begin
               pc_d = pc_q;
            end
            if (op_s == OP_HALT) begin
               state_d = S_HALT;
            end else if (run) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HALT: begin
            halted  = 1'b1;
            state_d = S_HALT;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
